// File: rtl/csr_regfile_if.sv
// CSR access bus between the ALU CSR-op initiator (master) and the machine-mode
// CSR register file (slave): generic and dedicated ports plus trap/return controls.
interface csr_regfile_if #(
   parameter int XLEN = 64
);
   logic [11:0]     CSR_Read_Addr;
   logic [XLEN-1:0] CSR_Read_Data;
   logic [11:0]     CSR_Write_Addr;
   logic [XLEN-1:0] CSR_Write_Data;
   logic            Write_En;
   logic [XLEN-1:0] mcause_Write_Data;
   logic            mcause_En;
   logic [XLEN-1:0] mcause_Read_Data;
   logic [XLEN-1:0] mepc_Write_Data;
   logic            mepc_En;
   logic [XLEN-1:0] mepc_Read_Data;
   logic [XLEN-1:0] mtvec_Write_Data;
   logic            mtvec_En;
   logic [XLEN-1:0] mtvec_Read_Data;
   logic            ecall_valid;
   logic [XLEN-1:0] ecall_pc;
   logic            mret_valid;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] ret_target;
   logic            illegal_csr;

   modport master (
      output CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
      output mcause_Write_Data, mcause_En, mepc_Write_Data, mepc_En,
      output mtvec_Write_Data, mtvec_En, ecall_valid, ecall_pc, mret_valid,
      input  CSR_Read_Data, mcause_Read_Data, mepc_Read_Data, mtvec_Read_Data,
      input  trap_target, ret_target, illegal_csr
   );

   modport slave (
      input  CSR_Read_Addr, CSR_Write_Addr, CSR_Write_Data, Write_En,
      input  mcause_Write_Data, mcause_En, mepc_Write_Data, mepc_En,
      input  mtvec_Write_Data, mtvec_En, ecall_valid, ecall_pc, mret_valid,
      output CSR_Read_Data, mcause_Read_Data, mepc_Read_Data, mtvec_Read_Data,
      output trap_target, ret_target, illegal_csr
   );
endinterface

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage for the NPC core: mstatus/mtvec/mscratch/mepc/mcause/mcycle,
// ecall trap entry, mret return, and trap/return target PCs for PC update.
module csr_regfile #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_0000_0000_1800
) (
   input logic           clk,
   input logic           rst,
   csr_regfile_if.slave  bus
);

   localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [11:0] ADDR_MTVEC    = 12'h305;
   localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [11:0] ADDR_MEPC     = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

   localparam logic [XLEN-1:0] MPP_MASK    = {{(XLEN-13){1'b0}}, 2'b11, 11'b000_0000_0000};
   localparam logic [XLEN-1:0] CAUSE_ECALL = {{(XLEN-4){1'b0}}, 4'd11};
   localparam logic [XLEN-1:0] ONE         = {{(XLEN-1){1'b0}}, 1'b1};

   // Direct mode only: the vector mode field is hardwired to zero.
   function automatic logic [XLEN-1:0] mask_mtvec(input logic [XLEN-1:0] d);
      mask_mtvec = {d[XLEN-1:2], 2'b00};
   endfunction

   function automatic logic [XLEN-1:0] mask_mepc(input logic [XLEN-1:0] d);
      mask_mepc = {d[XLEN-1:1], 1'b0};
   endfunction

   // M-only core: MPP always reads back as machine mode.
   function automatic logic [XLEN-1:0] mask_mstatus(input logic [XLEN-1:0] d);
      mask_mstatus = d | MPP_MASK;
   endfunction

   function automatic logic is_implemented(input logic [11:0] a);
      case (a)
         ADDR_MSTATUS, ADDR_MTVEC, ADDR_MSCRATCH,
         ADDR_MEPC, ADDR_MCAUSE, ADDR_MCYCLE: is_implemented = 1'b1;
         default:                             is_implemented = 1'b0;
      endcase
   endfunction

   logic [XLEN-1:0] mstatus_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mcycle_r;
   logic            illegal_r;

   logic [XLEN-1:0] mstatus_nxt_s, mtvec_nxt_s, mscratch_nxt_s, mepc_nxt_s;
   logic [XLEN-1:0] mcause_nxt_s, mcycle_nxt_s;
   logic            illegal_nxt_s;
   logic [XLEN-1:0] rd_data_s;

   logic gen_wr_mstatus_s, gen_wr_mtvec_s, gen_wr_mscratch_s;
   logic gen_wr_mepc_s, gen_wr_mcause_s, gen_wr_mcycle_s;

   // Generic write port address decode.
   always_comb begin
      gen_wr_mstatus_s  = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MSTATUS);
      gen_wr_mtvec_s    = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MTVEC);
      gen_wr_mscratch_s = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MSCRATCH);
      gen_wr_mepc_s     = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MEPC);
      gen_wr_mcause_s   = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MCAUSE);
      gen_wr_mcycle_s   = bus.Write_En && (bus.CSR_Write_Addr == ADDR_MCYCLE);
      illegal_nxt_s     = bus.Write_En && !is_implemented(bus.CSR_Write_Addr);
   end

   // Per-CSR next-state: ecall over mret over dedicated ports over generic writes.
   always_comb begin
      mstatus_nxt_s = mstatus_r;
      if (bus.ecall_valid) begin
         mstatus_nxt_s[7] = mstatus_r[3];
         mstatus_nxt_s[3] = 1'b0;
      end else if (bus.mret_valid) begin
         mstatus_nxt_s[3] = mstatus_r[7];
         mstatus_nxt_s[7] = 1'b1;
      end else if (gen_wr_mstatus_s) begin
         mstatus_nxt_s = mask_mstatus(bus.CSR_Write_Data);
      end else begin
         mstatus_nxt_s = mstatus_r;
      end

      mepc_nxt_s = mepc_r;
      if (bus.ecall_valid) begin
         mepc_nxt_s = mask_mepc(bus.ecall_pc);
      end else if (bus.mepc_En) begin
         mepc_nxt_s = mask_mepc(bus.mepc_Write_Data);
      end else if (gen_wr_mepc_s) begin
         mepc_nxt_s = mask_mepc(bus.CSR_Write_Data);
      end else begin
         mepc_nxt_s = mepc_r;
      end

      mcause_nxt_s = mcause_r;
      if (bus.ecall_valid) begin
         mcause_nxt_s = CAUSE_ECALL;
      end else if (bus.mcause_En) begin
         mcause_nxt_s = bus.mcause_Write_Data;
      end else if (gen_wr_mcause_s) begin
         mcause_nxt_s = bus.CSR_Write_Data;
      end else begin
         mcause_nxt_s = mcause_r;
      end

      mtvec_nxt_s = mtvec_r;
      if (bus.mtvec_En) begin
         mtvec_nxt_s = mask_mtvec(bus.mtvec_Write_Data);
      end else if (gen_wr_mtvec_s) begin
         mtvec_nxt_s = mask_mtvec(bus.CSR_Write_Data);
      end else begin
         mtvec_nxt_s = mtvec_r;
      end

      mscratch_nxt_s = mscratch_r;
      if (gen_wr_mscratch_s) begin
         mscratch_nxt_s = bus.CSR_Write_Data;
      end else begin
         mscratch_nxt_s = mscratch_r;
      end

      // A software write replaces that cycle's increment.
      mcycle_nxt_s = mcycle_r + ONE;
      if (gen_wr_mcycle_s) begin
         mcycle_nxt_s = bus.CSR_Write_Data;
      end else begin
         mcycle_nxt_s = mcycle_r + ONE;
      end
   end

   // CSR state registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mstatus_r  <= MSTATUS_RST;
         mtvec_r    <= {XLEN{1'b0}};
         mscratch_r <= {XLEN{1'b0}};
         mepc_r     <= {XLEN{1'b0}};
         mcause_r   <= {XLEN{1'b0}};
         mcycle_r   <= {XLEN{1'b0}};
         illegal_r  <= 1'b0;
      end else begin
         mstatus_r  <= mstatus_nxt_s;
         mtvec_r    <= mtvec_nxt_s;
         mscratch_r <= mscratch_nxt_s;
         mepc_r     <= mepc_nxt_s;
         mcause_r   <= mcause_nxt_s;
         mcycle_r   <= mcycle_nxt_s;
         illegal_r  <= illegal_nxt_s;
      end
   end

   // Combinational generic read mux; unimplemented addresses read as zero.
   always_comb begin
      rd_data_s = {XLEN{1'b0}};
      case (bus.CSR_Read_Addr)
         ADDR_MSTATUS:  rd_data_s = mstatus_r;
         ADDR_MTVEC:    rd_data_s = mtvec_r;
         ADDR_MSCRATCH: rd_data_s = mscratch_r;
         ADDR_MEPC:     rd_data_s = mepc_r;
         ADDR_MCAUSE:   rd_data_s = mcause_r;
         ADDR_MCYCLE:   rd_data_s = mcycle_r;
         default:       rd_data_s = {XLEN{1'b0}};
      endcase
   end

   assign bus.CSR_Read_Data    = rd_data_s;
   assign bus.mcause_Read_Data = mcause_r;
   assign bus.mepc_Read_Data   = mepc_r;
   assign bus.mtvec_Read_Data  = mtvec_r;
   assign bus.trap_target      = mtvec_r;
   assign bus.ret_target       = mepc_r;
   assign bus.illegal_csr      = illegal_r;

endmodule

// File: tb/tb_csr_regfile.sv
// Scenario-based bench for csr_regfile: expected values are queued when stimulus is
// driven and popped for comparison once the DUT response is due.
module tb_csr_regfile;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   passes = 0;
   logic [63:0] exp_q[$];
   logic [63:0] exp_v;

   always #5 clk = ~clk;

   csr_regfile_if #(.XLEN(64)) bus();

   csr_regfile #(.XLEN(64), .MSTATUS_RST(64'h0000_0000_0000_1800)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic idle_inputs();
      bus.CSR_Write_Addr    = 12'h000;
      bus.CSR_Write_Data    = 64'h0;
      bus.Write_En          = 1'b0;
      bus.mcause_Write_Data = 64'h0;
      bus.mcause_En         = 1'b0;
      bus.mepc_Write_Data   = 64'h0;
      bus.mepc_En           = 1'b0;
      bus.mtvec_Write_Data  = 64'h0;
      bus.mtvec_En          = 1'b0;
      bus.ecall_valid       = 1'b0;
      bus.ecall_pc          = 64'h0;
      bus.mret_valid        = 1'b0;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      bus.CSR_Read_Addr = 12'h300;
      exp_q.push_back(64'h1800);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      repeat (2) edge_sample();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL reset_mstatus got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mtvec_Read_Data !== exp_v) $display("FAIL reset_mtvec got %h want %h", bus.mtvec_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mepc_Read_Data !== exp_v) $display("FAIL reset_mepc got %h want %h", bus.mepc_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mcause_Read_Data !== exp_v) $display("FAIL reset_mcause got %h want %h", bus.mcause_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if ({63'b0, bus.illegal_csr} !== exp_v) $display("FAIL reset_illegal got %b want %h", bus.illegal_csr, exp_v); else passes++;
      @(negedge clk);
      rst = 1'b1;
      bus.CSR_Read_Addr = 12'hB00;
      exp_q.push_back(64'd5);
      repeat (5) edge_sample();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL mcycle_after_reset got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
   endtask

   task automatic test_generic_write();
      @(negedge clk);
      bus.Write_En       = 1'b1;
      bus.CSR_Write_Addr = 12'h305;
      bus.CSR_Write_Data = 64'h8000_0003;
      bus.CSR_Read_Addr  = 12'h305;
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h8000_0000);
      exp_q.push_back(64'h8000_0000);
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL same_cycle_read got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mtvec_Read_Data !== exp_v) $display("FAIL mtvec_masked got %h want %h", bus.mtvec_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.trap_target !== exp_v) $display("FAIL trap_target got %h want %h", bus.trap_target, exp_v); else passes++;
      // MPP cannot be cleared; mepc bit 0 is dropped on the dedicated port.
      @(negedge clk);
      bus.Write_En        = 1'b1;
      bus.CSR_Write_Addr  = 12'h300;
      bus.CSR_Write_Data  = 64'h0;
      bus.mepc_En         = 1'b1;
      bus.mepc_Write_Data = 64'h201;
      bus.CSR_Read_Addr   = 12'h300;
      exp_q.push_back(64'h1800);
      exp_q.push_back(64'h200);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL mstatus_mpp_kept got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mepc_Read_Data !== exp_v) $display("FAIL mepc_bit0 got %h want %h", bus.mepc_Read_Data, exp_v); else passes++;
   endtask

   task automatic test_trap();
      @(negedge clk);
      bus.Write_En       = 1'b1;
      bus.CSR_Write_Addr = 12'h300;
      bus.CSR_Write_Data = 64'h1808;
      bus.CSR_Read_Addr  = 12'h300;
      edge_sample();
      @(negedge clk);
      idle_inputs();
      bus.ecall_valid = 1'b1;
      bus.ecall_pc    = 64'h8000_0104;
      exp_q.push_back(64'h8000_0104);
      exp_q.push_back(64'd11);
      exp_q.push_back(64'h1880);
      exp_q.push_back(64'h8000_0104);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mepc_Read_Data !== exp_v) $display("FAIL ecall_mepc got %h want %h", bus.mepc_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mcause_Read_Data !== exp_v) $display("FAIL ecall_mcause got %h want %h", bus.mcause_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL ecall_mstatus got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.ret_target !== exp_v) $display("FAIL ret_target got %h want %h", bus.ret_target, exp_v); else passes++;
      @(negedge clk);
      bus.mret_valid = 1'b1;
      exp_q.push_back(64'h1888);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL mret_mstatus got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      // ecall and mret together: ecall wins (MIE=1 -> MPIE=1, MIE=0).
      @(negedge clk);
      bus.ecall_valid = 1'b1;
      bus.ecall_pc    = 64'h8000_0201;
      bus.mret_valid  = 1'b1;
      exp_q.push_back(64'h1880);
      exp_q.push_back(64'h8000_0200);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL ecall_over_mret got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mepc_Read_Data !== exp_v) $display("FAIL ecall_pc_bit0 got %h want %h", bus.mepc_Read_Data, exp_v); else passes++;
   endtask

   task automatic test_priority();
      @(negedge clk);
      bus.ecall_valid     = 1'b1;
      bus.ecall_pc        = 64'h100;
      bus.mepc_En         = 1'b1;
      bus.mepc_Write_Data = 64'h200;
      bus.mcause_En       = 1'b1;
      bus.mcause_Write_Data = 64'h55;
      bus.Write_En        = 1'b1;
      bus.CSR_Write_Addr  = 12'h340;
      bus.CSR_Write_Data  = 64'hAA;
      bus.CSR_Read_Addr   = 12'h340;
      exp_q.push_back(64'h100);
      exp_q.push_back(64'hAA);
      exp_q.push_back(64'd11);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mepc_Read_Data !== exp_v) $display("FAIL prio_mepc got %h want %h", bus.mepc_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL prio_mscratch got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mcause_Read_Data !== exp_v) $display("FAIL prio_mcause got %h want %h", bus.mcause_Read_Data, exp_v); else passes++;
      // Dedicated port beats generic write to the same CSR.
      @(negedge clk);
      bus.mtvec_En         = 1'b1;
      bus.mtvec_Write_Data = 64'h4000_0004;
      bus.Write_En         = 1'b1;
      bus.CSR_Write_Addr   = 12'h305;
      bus.CSR_Write_Data   = 64'h1234_0000;
      exp_q.push_back(64'h4000_0004);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.mtvec_Read_Data !== exp_v) $display("FAIL prio_mtvec got %h want %h", bus.mtvec_Read_Data, exp_v); else passes++;
   endtask

   task automatic test_illegal();
      @(negedge clk);
      bus.Write_En       = 1'b1;
      bus.CSR_Write_Addr = 12'h7C0;
      bus.CSR_Write_Data = 64'hDEAD_BEEF;
      bus.CSR_Read_Addr  = 12'h7C0;
      exp_q.push_back(64'd1);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'hAA);
      exp_q.push_back(64'd0);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if ({63'b0, bus.illegal_csr} !== exp_v) $display("FAIL illegal_pulse got %b want %h", bus.illegal_csr, exp_v); else passes++;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL illegal_read got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      bus.CSR_Read_Addr = 12'h340;
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL illegal_no_change got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      edge_sample();
      exp_v = exp_q.pop_front(); checks++;
      if ({63'b0, bus.illegal_csr} !== exp_v) $display("FAIL illegal_one_cycle got %b want %h", bus.illegal_csr, exp_v); else passes++;
   endtask

   task automatic test_mcycle();
      @(negedge clk);
      bus.Write_En       = 1'b1;
      bus.CSR_Write_Addr = 12'hB00;
      bus.CSR_Write_Data = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.CSR_Read_Addr  = 12'hB00;
      exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      edge_sample();
      idle_inputs();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL mcycle_write got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      edge_sample();
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL mcycle_wrap got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      repeat (3) edge_sample();
      #2;
      rst = 1'b0;
      #1;
      exp_v = exp_q.pop_front(); checks++;
      if (bus.CSR_Read_Data !== exp_v) $display("FAIL async_reset got %h want %h", bus.CSR_Read_Data, exp_v); else passes++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      bus.CSR_Read_Addr = 12'h000;
      idle_inputs();
      test_reset();
      test_generic_write();
      test_trap();
      test_priority();
      test_illegal();
      test_mcycle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage and trap-state responder for the NPC core.
- Serves the ALU CSR-op initiator:
  - generic read/write port used by csrrw/csrrs/csrrc;
  - dedicated mcause/mepc/mtvec read/write ports.
- Also handles ecall trap entry and mret return.
- Provides trap/return target PCs to the PC-update logic.
- Holds a free-running mcycle counter.

Parameters:
- XLEN, 64, data width of every CSR and data port.
- MSTATUS_RST, 64'h0000_0000_0000_1800, mstatus reset value (MPP=2'b11).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- CSR_Read_Addr  in  12  generic read address.
- CSR_Read_Data  out  XLEN  combinational read data for CSR_Read_Addr.
- CSR_Write_Addr  in  12  generic write address.
- CSR_Write_Data  in  XLEN  generic write data.
- Write_En  in  1  generic write strobe.
- mcause_Write_Data  in  XLEN  dedicated mcause write data.
- mcause_En  in  1  dedicated mcause write strobe.
- mcause_Read_Data  out  XLEN  current mcause.
- mepc_Write_Data  in  XLEN  dedicated mepc write data.
- mepc_En  in  1  dedicated mepc write strobe.
- mepc_Read_Data  out  XLEN  current mepc.
- mtvec_Write_Data  in  XLEN  dedicated mtvec write data.
- mtvec_En  in  1  dedicated mtvec write strobe.
- mtvec_Read_Data  out  XLEN  current mtvec.
- ecall_valid  in  1  retire of an ecall this cycle.
- ecall_pc  in  XLEN  PC of that ecall.
- mret_valid  in  1  retire of an mret this cycle.
- trap_target  out  XLEN  combinational, equals mtvec.
- ret_target  out  XLEN  combinational, equals mepc.
- illegal_csr  out  1  registered one-cycle pulse for a generic write to an unimplemented address.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300
  - mtvec 0x305
  - mscratch 0x340
  - mepc 0x341
  - mcause 0x342
  - mcycle 0xB00
- Reset (rst=0, asynchronous):
  - mstatus=MSTATUS_RST;
  - all other CSRs = 0;
  - illegal_csr = 0.
  - Takes effect immediately and holds while rst=0.
  - An in-flight write or trap is discarded.
- Reads: CSR_Read_Data is combinational.
  - Unimplemented address returns 0.
  - A read in the same cycle as a write returns the old value; the new value is visible from the next cycle.
- Generic write: Write_En=1 writes CSR_Write_Data to CSR_Write_Addr at the clock edge.
  - Unimplemented address: no state change, illegal_csr=1 in the following cycle only.
- Write masking:
  - mtvec bits[1:0] forced 0 (direct mode only);
  - mepc bit 0 forced 0;
  - mstatus is fully writable except MPP, which stays 2'b11 (M-only core).
- Trap entry, ecall_valid=1, all updated in one edge:
  - mepc <= ecall_pc with bit0 cleared;
  - mcause <= 64'd11;
  - mstatus.MPIE(bit7) <= mstatus.MIE(bit3);
  - mstatus.MIE <= 0.
- mret, mret_valid=1, one edge:
  - mstatus.MIE <= MPIE;
  - MPIE <= 1.
- Per-CSR priority within one cycle, highest first:
  1. ecall_valid
  2. mret_valid
  3. dedicated *_En
  4. Write_En
- Priority boundary cases:
  - A lower-priority write to a CSR also touched by a higher-priority source is dropped.
  - Writes to unaffected CSRs still occur, e.g. ecall + generic mscratch write → both happen.
  - ecall_valid and mret_valid together: ecall wins; the mret is ignored.
- mcycle:
  - Increments by 1 every cycle out of reset, wrapping 2^64-1 → 0.
  - A write in the same cycle wins: mcycle <= write data, no increment that cycle.
- Outputs: trap_target/ret_target are combinational from current register values, zero added latency.
- The dedicated *_Read_Data outputs mirror their registers continuously.

Test Plan:
- Reset behaviour: hold rst=0 → CSR_Read_Data(0x300)=64'h1800, mtvec/mepc/mcause=0, illegal_csr=0. Release rst; after 5 cycles, read 0xB00 → 5.
- Generic write with masking and read-after-write timing:
  - Write_En, addr 0x305, data 64'h8000_0003 → next cycle mtvec_Read_Data=64'h8000_0000 and trap_target=64'h8000_0000.
  - Same-cycle read of 0x305 returns the old value 0.
- Trap entry/return: mstatus=64'h1808, ecall_valid with ecall_pc=64'h8000_0104:
  - next cycle mepc=64'h8000_0104, mcause=11, mstatus=64'h1880, ret_target=64'h8000_0104;
  - then mret_valid → mstatus=64'h1888.
- Priority: in one cycle, ecall_valid with ecall_pc=64'h100, mepc_En with data 64'h200, and Write_En to 0x340 with data 64'hAA → mepc=64'h100, mscratch=64'hAA.
- Illegal write: Write_En to address 0x7C0 → no CSR changes; illegal_csr high for exactly one cycle after the write; CSR_Read_Data(0x7C0)=0.
- mcycle write and wrap:
  - write 0xB00 with 64'hFFFF_FFFF_FFFF_FFFF → next cycle reads all-ones, following cycle 0.
  - Asserting rst mid-count → 0 immediately, without waiting for a clock edge.
